// File: rtl/hw_accel_binary_erosion_pkg.sv
// Shared types and constants for the binary erosion accelerator.
// The structuring element is selected in the top by HW_ACCEL_EROSION_CROSS_SE_EN.
package hw_accel_binary_erosion_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    localparam int KERNEL_SIZE = 3;
    localparam int KERNEL_TAPS = KERNEL_SIZE * KERNEL_SIZE;

    // Window bit r*KERNEL_SIZE+c: row 0 is the oldest line, column 2 the newest pixel.
    localparam logic [KERNEL_TAPS-1:0] SE_SQUARE = 9'b111_111_111;
    localparam logic [KERNEL_TAPS-1:0] SE_CROSS  = 9'b010_111_010;

    // A centre survives erosion only if every pixel under the element is set.
    function automatic logic erode_hit(input logic [KERNEL_TAPS-1:0] win,
                                       input logic [KERNEL_TAPS-1:0] mask);
        return &(win | ~mask);
    endfunction

endpackage

// File: rtl/hw_accel_bit_line_buffer.sv
// Two-line 1-bit delay: taps[0] is the incoming bit, taps[1] the bit one line
// earlier, taps[2] the bit two lines earlier. Advances only on en.
module hw_accel_bit_line_buffer
    import hw_accel_binary_erosion_pkg::*;
#(
    parameter int DEPTH = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   din,
    output logic [KERNEL_SIZE-1:0] taps
);

    logic [DEPTH-1:0] row1_sr;
    logic [DEPTH-1:0] row2_sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row1_sr <= '0;
            row2_sr <= '0;
        end else if (en) begin
            row1_sr <= {row1_sr[DEPTH-2:0], din};
            row2_sr <= {row2_sr[DEPTH-2:0], row1_sr[DEPTH-1]};
        end
    end

    assign taps = {row2_sr[DEPTH-1], row1_sr[DEPTH-1], din};

endmodule

// File: rtl/hw_accel_binary_erosion.sv
// Streaming binary erosion over a raster frame with a 3x3 window.
// Define HW_ACCEL_EROSION_CROSS_SE_EN for the 5-pixel cross element; default is the full square.
module hw_accel_binary_erosion
    import hw_accel_binary_erosion_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 10,
    parameter int IMG_HEIGHT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] pixel_in,
    input  logic                  pixel_in_valid,
    output logic [DATA_WIDTH-1:0] pixel_out,
    output logic                  pixel_out_valid,
    output logic                  frame_done,
    output logic                  busy,
    output state_t                dbg_state
);

    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

`ifdef HW_ACCEL_EROSION_CROSS_SE_EN
    localparam logic [KERNEL_TAPS-1:0] SE_MASK = SE_CROSS;
`else
    localparam logic [KERNEL_TAPS-1:0] SE_MASK = SE_SQUARE;
`endif

    state_t                 state;
    state_t                 next_state;
    logic [XW-1:0]          in_x;
    logic [YW-1:0]          in_y;
    logic [XW-1:0]          out_x;
    logic [YW-1:0]          out_y;
    logic [KERNEL_SIZE-1:0] taps;
    logic [KERNEL_TAPS-1:0] win;
    logic                   s1_valid;
    logic                   accept;
    logic                   in_last;
    logic                   in_run_start;
    logic                   in_past_fill;
    logic                   flush_emit;
    logic                   emit;
    logic                   out_border;
    logic                   out_last;
    logic                   out_hit;

    // Handshake: valid-only, no back-pressure. A pixel is taken on every rising
    // edge with pixel_in_valid high outside FLUSH; in FLUSH it is dropped.
    // pixel_out is meaningful only in cycles with pixel_out_valid high.
    assign accept       = pixel_in_valid && (state != FLUSH);
    assign in_last      = (in_x == X_LAST) && (in_y == Y_LAST);
    assign in_run_start = (in_x == XW'(1)) && (in_y == YW'(1));
    // Index >= W+1: enough lines have arrived for the window to have a centre.
    assign in_past_fill = (in_y != '0) && !((in_y == YW'(1)) && (in_x == '0));

    hw_accel_bit_line_buffer #(
        .DEPTH (IMG_WIDTH)
    ) u_line_buf (
        .clk  (clk),
        .rst  (rst),
        .en   (accept),
        .din  (|pixel_in),
        .taps (taps)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_x <= '0;
            in_y <= '0;
        end else if (accept) begin
            if (in_x == X_LAST) begin
                in_x <= '0;
                in_y <= (in_y == Y_LAST) ? '0 : in_y + YW'(1);
            end else begin
                in_x <= in_x + XW'(1);
            end
        end
    end

    // Stage 1: shift the new column (oldest line in row 0) into the window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win      <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= accept && in_past_fill;
            if (accept) begin
                win <= {taps[0], win[8:7], taps[1], win[5:4], taps[2], win[2:1]};
            end
        end
    end

    // Flush fills any cycle without a window result until the last output shows.
    assign flush_emit = (state == FLUSH) && !s1_valid && !(pixel_out_valid && frame_done);
    assign emit       = s1_valid || flush_emit;
    assign out_border = (out_x == '0) || (out_x == X_LAST) || (out_y == '0) || (out_y == Y_LAST);
    assign out_last   = (out_x == X_LAST) && (out_y == Y_LAST);
    assign out_hit    = s1_valid && !out_border && erode_hit(win, SE_MASK);

    // Stage 2: output register and output raster position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_out       <= '0;
            pixel_out_valid <= 1'b0;
            frame_done      <= 1'b0;
            out_x           <= '0;
            out_y           <= '0;
        end else begin
            pixel_out       <= out_hit ? '1 : '0;
            pixel_out_valid <= emit;
            frame_done      <= emit && out_last;
            if (emit) begin
                if (out_x == X_LAST) begin
                    out_x <= '0;
                    out_y <= (out_y == Y_LAST) ? '0 : out_y + YW'(1);
                end else begin
                    out_x <= out_x + XW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = (state != IDLE);
        dbg_state  = state;
        case (state)
            IDLE:    if (accept) next_state = FILL;
            FILL:    if (accept && in_run_start) next_state = RUN;
            RUN:     if (accept && in_last) next_state = FLUSH;
            FLUSH:   if (pixel_out_valid && frame_done) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_hw_accel_binary_erosion.sv
// Bench for hw_accel_binary_erosion: image-level erosion model feeding an
// expected queue, checked on every valid output, plus fixed-frame literals.
module tb_hw_accel_binary_erosion;
    import hw_accel_binary_erosion_pkg::*;

    localparam int DW = 8;
    localparam int W  = 10;
    localparam int H  = 4;
    localparam int N  = W * H;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] pixel_in = '0;
    logic          pixel_in_valid = 1'b0;
    logic [DW-1:0] pixel_out;
    logic          pixel_out_valid;
    logic          frame_done;
    logic          busy;
    state_t        dbg_state;

    hw_accel_binary_erosion #(
        .DATA_WIDTH (DW),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pixel_in        (pixel_in),
        .pixel_in_valid  (pixel_in_valid),
        .pixel_out       (pixel_out),
        .pixel_out_valid (pixel_out_valid),
        .frame_done      (frame_done),
        .busy            (busy),
        .dbg_state       (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int            n_vec = 0;
    int            n_err = 0;
    logic [DW:0]   exp_q[$];
    logic [DW-1:0] frame_pix [H][W];
    int            first_cyc = -1;
    int            done_cyc  = -1;
    int            done_cnt  = 0;
    int            ones_seen = 0;

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin : compare
        logic [DW:0] e;
        if (pixel_out_valid) begin
            if (exp_q.size() == 0) begin
                check("output_with_empty_queue", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("pixel_and_done", int'({frame_done, pixel_out}), int'(e));
            end
            if (first_cyc < 0) first_cyc = cyc;
            if (pixel_out == 8'hFF) ones_seen++;
            if (frame_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end else begin
            check("done_without_valid", int'(frame_done), 0);
        end
    end

    // Reference: erosion computed directly on the stored image.
    function automatic int push_model();
        int ones = 0;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                logic hit;
                hit = (x > 0) && (x < W - 1) && (y > 0) && (y < H - 1);
                if (hit) begin
                    for (int dy = -1; dy <= 1; dy++) begin
                        for (int dx = -1; dx <= 1; dx++) begin
`ifdef HW_ACCEL_EROSION_CROSS_SE_EN
                            if (dx != 0 && dy != 0) continue;
`endif
                            if (frame_pix[y+dy][x+dx] == '0) hit = 1'b0;
                        end
                    end
                end
                exp_q.push_back({(y == H - 1) && (x == W - 1), hit ? 8'hFF : 8'h00});
                if (hit) ones++;
            end
        end
        return ones;
    endfunction

    // ---------------- frame builders ----------------
    task automatic fill_const(input logic [DW-1:0] v);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                frame_pix[y][x] = v;
    endtask

    task automatic fill_random();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                frame_pix[y][x] = ($urandom_range(0, 99) < 85) ? DW'($urandom_range(1, 255)) : '0;
    endtask

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: continuous, 1: every other cycle, 2: random gaps.
    task automatic drive_frame(input int mode, input int count, input int junk, output int t0);
        t0 = -1;
        for (int k = 0; k < count; k++) begin
            int gaps;
            gaps = 0;
            if (mode == 1 && k > 0) gaps = 1;
            if (mode == 2) gaps = $urandom_range(0, 2);
            repeat (gaps) begin
                tick();
                pixel_in_valid = 1'b0;
                pixel_in       = DW'($urandom_range(0, 255));
            end
            tick();
            pixel_in_valid = 1'b1;
            pixel_in       = frame_pix[k / W][k % W];
            if (k == 0) t0 = cyc;
        end
        // Pixels offered right after the last one land in FLUSH and must vanish.
        repeat (junk) begin
            tick();
            pixel_in_valid = 1'b1;
            pixel_in       = DW'($urandom_range(1, 255));
        end
        tick();
        pixel_in_valid = 1'b0;
        pixel_in       = '0;
    endtask

    task automatic wait_idle(input string tag, output int idle_cyc);
        int budget = 0;
        while (busy && budget < 300) begin
            tick();
            budget++;
        end
        check({tag, "_idle_timeout"}, int'(busy), 0);
        idle_cyc = cyc;
    endtask

    task automatic run_frame(input string tag, input int mode, input int junk, input int exp_ones);
        int t0, idle_cyc, model_ones;
        model_ones = push_model();
        if (exp_ones >= 0) check({tag, "_model_ones"}, model_ones, exp_ones);
        first_cyc = -1;
        done_cyc  = -1;
        done_cnt  = 0;
        ones_seen = 0;
        drive_frame(mode, N, junk, t0);
        wait_idle(tag, idle_cyc);
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_queue_left"}, exp_q.size(), 0);
        check({tag, "_ones_seen"}, ones_seen, model_ones);
        if (exp_ones >= 0) check({tag, "_ones_literal"}, ones_seen, exp_ones);
        if (mode == 0) begin
            check({tag, "_first_valid_lat"}, first_cyc - t0, 13);
            check({tag, "_frame_done_lat"}, done_cyc - t0, 52);
            check({tag, "_busy_low_lat"}, idle_cyc - t0, 53);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int t0;
        int exp_hole_ones;
`ifdef HW_ACCEL_EROSION_CROSS_SE_EN
        exp_hole_ones = 12;
`else
        exp_hole_ones = 10;
`endif
        repeat (3) tick();
        check("rst_pixel_out", int'(pixel_out), 0);
        check("rst_out_valid", int'(pixel_out_valid), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_state", int'(dbg_state), int'(IDLE));
        rst = 1'b0;
        tick();
        check("post_rst_busy", int'(busy), 0);

        fill_const(8'hFF);
        run_frame("square", 0, 0, 16);

        fill_const(8'hFF);
        frame_pix[1][4] = '0;
        run_frame("hole", 0, 0, exp_hole_ones);

        fill_const(8'hFF);
        run_frame("alternate", 1, 0, 16);

        // Abort a frame after 20 pixels: outputs 0..8 come out before reset.
        fill_random();
        void'(push_model());
        drive_frame(0, 20, 0, t0);
        repeat (4) tick();
        check("abort_outputs_before_rst", N - exp_q.size(), 9);
        rst = 1'b1;
        exp_q.delete();
        tick();
        tick();
        check("abort_rst_state", int'(dbg_state), int'(IDLE));
        check("abort_rst_busy", int'(busy), 0);
        rst = 1'b0;
        tick();
        fill_const(8'hFF);
        run_frame("after_abort", 0, 0, 16);

        for (int f = 0; f < 6; f++) begin
            fill_random();
            run_frame($sformatf("random%0d", f), 2, $urandom_range(0, 4), -1);
        end

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hw_accel_binary_erosion.md
HW_ACCEL_BINARY_EROSION -- requirements
Module: hw_accel_binary_erosion

Interface
REQ-001 The block SHALL expose parameters, one per line:
  DATA_WIDTH  8   pixel width in bits
  IMG_WIDTH   10  pixels per line (W)
  IMG_HEIGHT  4   lines per frame (H)
REQ-002 The block SHALL expose ports, one per line:
  clk              in   1           clock, all logic on rising edge
  rst              in   1           reset, asynchronous, active-high
  pixel_in         in   DATA_WIDTH  raster-order input pixel
  pixel_in_valid   in   1           pixel_in accepted this cycle
  pixel_out        out  DATA_WIDTH  eroded pixel, all-zeros or all-ones
  pixel_out_valid  out  1           pixel_out valid this cycle
  frame_done       out  1           one-cycle pulse with the final output pixel of a frame
  busy             out  1           high in FILL, RUN and FLUSH

Function
REQ-003 Input SHALL be binarized on acceptance: nonzero -> 1, zero -> 0; line storage holds 1 bit per pixel.
REQ-004 Output at centre (x,y) SHALL be all-ones iff every structuring-element pixel is 1, else all-zeros.
REQ-005 Border centres (x=0, y=0, x=W-1, y=H-1) SHALL output all-zeros.
REQ-006 Exactly W*H outputs per frame SHALL be emitted in raster order, with no gaps or duplicates.
REQ-007 Accepting input index k=y*W+x with k>=W+1 at cycle t SHALL produce output index k-(W+1) at t+2.
REQ-008 State machine: IDLE -> FILL on first accepted pixel; FILL -> RUN when input index W+1 is accepted; RUN -> FLUSH the cycle after index W*H-1 is accepted; FLUSH -> IDLE after the last output.
REQ-009 FLUSH SHALL emit the remaining W+1 outputs, all zero, on consecutive cycles, with the first flush output one cycle after the last RUN output.
REQ-010 pixel_in_valid during FLUSH SHALL be ignored and the pixel dropped; IDLE resumes with the next pixel as (0,0).
REQ-011 Gaps in pixel_in_valid during FILL/RUN SHALL stall the pipeline without altering results.
REQ-012 frame_done SHALL assert in the same cycle as pixel_out_valid for output index W*H-1 only.
REQ-013 x/y counters SHALL wrap at W-1/H-1 and be sized $clog2 of the respective parameter.

Reset
REQ-014 On rst: pixel_out=0, pixel_out_valid=0, frame_done=0, busy=0, state=IDLE, and all counters, window and line-buffer bits cleared.
REQ-015 Reset mid-frame SHALL abort the frame; the first pixel accepted after release is (0,0), and no stale output is emitted.

Configuration
REQ-016 With HW_ACCEL_EROSION_CROSS_SE_EN defined, the structuring element SHALL be the 5-pixel cross (centre plus N/S/E/W). Without it, the element SHALL be the full 3x3 square.

Structure
REQ-017 The shared package SHALL hold the state encoding (IDLE, FILL, RUN, FLUSH) and the kernel size constant 3.
REQ-018 The 2-line 1-bit delay SHALL be the sub-module hw_accel_bit_line_buffer (depth W, taps for current, previous and second-previous rows).

Verification (W=10, H=4, continuous valid from t0 unless stated)
REQ-019 All-255 frame -> 40 outputs; 16 interior (x 1..8, y 1..2) = 255; all border = 0.
REQ-020 All-255 except 0 at (4,1) -> interior at x 3..5, y 1..2 = 0; 10 interior outputs = 255.
REQ-021 Timing -> first pixel_out_valid at t0+13; last RUN output at t0+41; flush outputs at t0+42..t0+52; frame_done at t0+52; busy low at t0+53.
REQ-022 Valid every other cycle, all-255 frame -> same 40 values as REQ-019; frame_done exactly once.
REQ-023 rst after 20 accepted pixels, then an all-255 frame -> exactly 40 outputs, matching REQ-019.
REQ-024 HW_ACCEL_EROSION_CROSS_SE_EN defined, REQ-020 stimulus -> zeros at (3,1), (4,1), (5,1), (4,2); 12 interior outputs = 255.
